// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch front end (Word, Instruction, FIFO entry, FSM states).
// Optional statistics counters in fetch_stage are enabled by defining FETCH_STATS_EN.
package fetch_stage_pkg;

   typedef logic [31:0] Word;
   typedef logic [31:0] Instruction;

   typedef struct packed {
      Word        pc;
      Instruction instr;
   } FetchEntry;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_e;

   localparam Word PC_STEP = 32'd4;

   function automatic Word align_word(input Word addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with a flush input; clear wins over push/pop.
// The head reads as zero while the FIFO is empty.
module fetch_fifo
   import fetch_stage_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_push,
   input  FetchEntry                  i_data,
   input  logic                       i_pop,
   input  logic                       i_clear,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_valid,
   output FetchEntry                  o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   FetchEntry     r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_pop;

   assign w_do_pop = i_pop && (r_count != '0);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({i_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_valid = (r_count != '0);
   assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

   fetch_fifo_chk #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_chk (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (i_push),
      .i_pop   (w_do_pop),
      .i_clear (i_clear),
      .i_count (r_count)
   );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Checker for fetch_fifo: a push must never land on a full FIFO, because the
// fetch credit rule reserves a slot for every request in flight.
module fetch_fifo_chk #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic          clk,
   input logic          reset_n,
   input logic          i_push,
   input logic          i_pop,
   input logic          i_clear,
   input logic [CW-1:0] i_count
);

   a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
      !(i_push && !i_pop && !i_clear && (i_count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, credit-limited imem requests, response FIFO, redirect/halt.
// Define FETCH_STATS_EN to add the stat_fetched / stat_dropped counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter Word RESET_PC = 32'h0000_0000,
   parameter int  DEPTH    = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       imem_req_valid,
   input  logic       imem_req_ready,
   output Word        imem_req_addr,
   input  logic       imem_resp_valid,
   input  Instruction imem_resp_data,
   output logic       out_valid,
   input  logic       out_ready,
   output Instruction out_instr,
   output Word        out_pc,
   input  logic       redirect_valid,
   input  Word        redirect_pc,
   input  logic       halt
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_dropped
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = CW + 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   fetch_state_e  r_state;
   fetch_state_e  w_state_nxt;
   Word           r_fetch_pc;
   Word           r_deliver_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_drop_cnt;
   logic [CW-1:0] w_outstanding_nxt;
   logic [CW-1:0] w_count;
   logic [IW-1:0] w_inflight;
   logic          w_pop;
   logic          w_req_fire;
   logic          w_push;
   logic          w_dropping;
   FetchEntry     w_head;

   assign w_pop = out_valid && out_ready;
   // A pop this cycle frees a slot that a request issued now may claim.
   assign w_inflight = IW'(r_outstanding) + IW'(w_count) - IW'(w_pop);

   assign imem_req_valid = (r_state == ST_RUN) && !redirect_valid && !halt
                           && (w_inflight < IW'(DEPTH));
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   assign w_push     = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;
   assign w_dropping = imem_resp_valid && ((r_drop_cnt != '0) || redirect_valid);
   assign w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);

   // Run/halt state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: redirect always resumes, halt stops fetching otherwise.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (redirect_valid) begin
               w_state_nxt = ST_RUN;
            end else if (halt) begin
               w_state_nxt = ST_HALTED;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_HALTED: begin
            if (redirect_valid) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_HALTED;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // PCs, in-flight count and drop counter; a redirect drops everything still in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_pc    <= RESET_PC;
         r_deliver_pc  <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
         if (redirect_valid) begin
            r_fetch_pc   <= align_word(redirect_pc);
            r_deliver_pc <= align_word(redirect_pc);
            r_drop_cnt   <= w_outstanding_nxt;
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (w_push) begin
               r_deliver_pc <= r_deliver_pc + PC_STEP;
            end
            if (w_dropping) begin
               r_drop_cnt <= r_drop_cnt - CNT_ONE;
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  ('{pc: r_deliver_pc, instr: imem_resp_data}),
      .i_pop   (w_pop && !redirect_valid),
      .i_clear (redirect_valid),
      .o_count (w_count),
      .o_valid (out_valid),
      .o_head  (w_head)
   );

   assign out_pc    = w_head.pc;
   assign out_instr = w_head.instr;

`ifdef FETCH_STATS_EN
   logic [31:0] r_stat_fetched;
   logic [31:0] r_stat_dropped;

   // Delivered and discarded instruction counters, wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stat_fetched <= 32'd0;
         r_stat_dropped <= 32'd0;
      end else begin
         if (w_pop && !redirect_valid) begin
            r_stat_fetched <= r_stat_fetched + 32'd1;
         end
         if (w_dropping) begin
            r_stat_dropped <= r_stat_dropped + 32'd1;
         end
      end
   end

   assign stat_fetched = r_stat_fetched;
   assign stat_dropped = r_stat_dropped;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: an in-order memory model and a queue of expected
// {pc, instr} deliveries per redirect epoch; outputs are checked each cycle.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam int  DEPTH    = 4;
   localparam Word RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic imem_req_valid, imem_req_ready = 1'b0;
   Word  imem_req_addr;
   logic imem_resp_valid = 1'b0;
   Instruction imem_resp_data = 32'd0;
   logic out_valid, out_ready = 1'b0;
   Instruction out_instr;
   Word  out_pc;
   logic redirect_valid = 1'b0;
   Word  redirect_pc = 32'd0;
   logic halt = 1'b0;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched, stat_dropped;
`endif

   fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_STATS_EN
      , .stat_fetched(stat_fetched), .stat_dropped(stat_dropped)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int unsigned due; logic [31:0] data; int unsigned ep; } mem_t;
   typedef struct { int unsigned due; logic [31:0] pc; logic [31:0] data; } exp_t;

   mem_t mem_q[$];
   exp_t exp_q[$];
   int unsigned cyc, last_due, epoch;
   Word exp_pc;
   bit  halted;
   int  vectors = 0, miscompares = 0;
   int  lat = 1, rdy_pct = 100, ordy_pct = 100, redir_pct = 0, halt_pct = 0;
   bit  f_en = 0, f_redir = 0, f_halt = 0;
   Word f_rpc = 32'd0;
   int unsigned s_cyc;
   bit  s_fire, s_out_valid;
   Word s_req_addr, s_out_pc;
   int  req_cnt, pop_cnt;
   int unsigned exp_fetched, exp_dropped;

   task automatic apply_reset();
      reset_n = 1'b0; redirect_valid = 1'b0; halt = 1'b0; out_ready = 1'b0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got valid=%b pc=%h instr=%h want 0/0/0", out_valid, out_pc, out_instr);
      end
`ifdef FETCH_STATS_EN
      vectors++;
      if (stat_fetched !== 32'd0 || stat_dropped !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_stats got %0d/%0d want 0/0", stat_fetched, stat_dropped);
      end
`endif
      mem_q.delete(); exp_q.delete();
      cyc = 0; last_due = 0; epoch = 0; exp_pc = RESET_PC; halted = 0;
      req_cnt = 0; pop_cnt = 0; exp_fetched = 0; exp_dropped = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // One clock cycle: drive memory/handshake inputs, check outputs, advance the model.
   task automatic step();
      int fifo_cnt;
      bit resp, pop, exp_rv, exp_ov, fire;
      mem_t m;
      int unsigned due;
      logic [31:0] d;
      @(negedge clk);
      resp = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         m = mem_q.pop_front();
         resp = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = m.data;
      end
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      out_ready = ($urandom_range(99) < ordy_pct);
      if (f_en) begin
         redirect_valid = f_redir; redirect_pc = f_rpc; halt = f_halt;
      end else begin
         redirect_valid = ($urandom_range(99) < redir_pct);
         redirect_pc = $urandom;
         halt = ($urandom_range(99) < halt_pct);
      end
      #1;
      fifo_cnt = 0;
      foreach (exp_q[i]) if (exp_q[i].due < cyc) fifo_cnt++;
      exp_ov = (fifo_cnt > 0);
      vectors++;
      if (out_valid !== exp_ov) begin
         miscompares++;
         $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_ov);
      end
      if (exp_ov) begin
         vectors++;
         if (out_pc !== exp_q[0].pc || out_instr !== exp_q[0].data) begin
            miscompares++;
            $display("FAIL out_entry cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                     cyc, out_pc, out_instr, exp_q[0].pc, exp_q[0].data);
         end
      end
      pop = exp_ov && out_ready;
      exp_rv = !redirect_valid && !halt && !halted
               && (mem_q.size() + int'(resp) + fifo_cnt - int'(pop) < DEPTH);
      vectors++;
      if (imem_req_valid !== exp_rv) begin
         miscompares++;
         $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc, imem_req_valid, exp_rv);
      end
      fire = (imem_req_valid === 1'b1) && imem_req_ready;
      if (fire) begin
         vectors++;
         if (imem_req_addr !== exp_pc) begin
            miscompares++;
            $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, imem_req_addr, exp_pc);
         end
      end
      s_cyc = cyc; s_fire = fire; s_req_addr = imem_req_addr;
      s_out_valid = exp_ov; s_out_pc = out_pc;
      if (resp && (m.ep != epoch || redirect_valid)) exp_dropped++;
      d = $urandom;
      due = cyc + lat;
      if (fire) begin
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back('{due, d, epoch});
         req_cnt++;
      end
      if (redirect_valid) begin
         exp_q.delete();
         exp_pc = redirect_pc & ~32'h3;
         halted = 0;
         epoch++;
      end else begin
         if (pop) begin
            void'(exp_q.pop_front());
            pop_cnt++; exp_fetched++;
         end
         if (fire) begin
            exp_q.push_back('{due, exp_pc, d});
            exp_pc = exp_pc + 32'd4;
         end
         if (halt) halted = 1;
      end
      cyc++;
   endtask

   task automatic forced_step(input bit r, input Word rpc, input bit h);
      f_en = 1; f_redir = r; f_rpc = rpc; f_halt = h;
      step();
      f_en = 0;
   endtask

   task automatic set_knobs(input int l, input int rp, input int op, input int dp, input int hp);
      lat = l; rdy_pct = rp; ordy_pct = op; redir_pct = dp; halt_pct = hp;
   endtask

   task automatic test_reset();
      set_knobs(1, 100, 100, 0, 0);
      apply_reset();
      step();
      vectors++;
      if (!s_fire || s_req_addr !== RESET_PC) begin
         miscompares++;
         $display("FAIL first_req got fire=%b addr=%h want 1/%h", s_fire, s_req_addr, RESET_PC);
      end
   endtask

   task automatic test_stream();
      set_knobs(1, 100, 100, 0, 0);
      apply_reset();
      repeat (20) begin
         step();
         if (s_cyc >= 2 && s_cyc <= 4) begin
            vectors++;
            if (!s_out_valid || s_out_pc !== 32'((s_cyc - 2) * 4)) begin
               miscompares++;
               $display("FAIL stream_pc cyc=%0d got=%h want=%h", s_cyc, s_out_pc, 32'((s_cyc - 2) * 4));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      set_knobs(1, 100, 0, 0, 0);
      apply_reset();
      repeat (12) step();
      vectors++;
      if (req_cnt != DEPTH) begin
         miscompares++;
         $display("FAIL bp_requests got=%0d want=%0d", req_cnt, DEPTH);
      end
      ordy_pct = 100;
      step();
      vectors++;
      if (req_cnt != DEPTH + 1) begin
         miscompares++;
         $display("FAIL bp_resume got=%0d want=%0d", req_cnt, DEPTH + 1);
      end
      repeat (10) step();
   endtask

   task automatic test_redirect();
      bit seen_out, seen_req;
      set_knobs(3, 100, 100, 0, 0);
      apply_reset();
      repeat (3) step();
      forced_step(1'b1, 32'h0000_0102, 1'b0);
      seen_out = 0; seen_req = 0;
      repeat (15) begin
         step();
         if (s_fire && !seen_req) begin
            seen_req = 1; vectors++;
            if (s_req_addr !== 32'h100) begin
               miscompares++;
               $display("FAIL redir_req got=%h want=%h", s_req_addr, 32'h100);
            end
         end
         if (s_out_valid && !seen_out) begin
            seen_out = 1; vectors++;
            if (s_out_pc !== 32'h100) begin
               miscompares++;
               $display("FAIL redir_out got=%h want=%h", s_out_pc, 32'h100);
            end
         end
      end
      vectors++;
      if (!seen_out || !seen_req || exp_dropped != 3) begin
         miscompares++;
         $display("FAIL redir_progress got out=%b req=%b dropped=%0d want 1/1/3", seen_out, seen_req, exp_dropped);
      end
`ifdef FETCH_STATS_EN
      vectors++;
      if (stat_dropped !== exp_dropped || stat_fetched !== exp_fetched) begin
         miscompares++;
         $display("FAIL redir_stats got %0d/%0d want %0d/%0d", stat_dropped, stat_fetched, exp_dropped, exp_fetched);
      end
`endif
   endtask

   task automatic test_halt();
      bit seen_req;
      set_knobs(2, 100, 100, 0, 0);
      apply_reset();
      repeat (2) step();
      forced_step(1'b0, 32'd0, 1'b1);
      repeat (8) step();
      vectors++;
      if (req_cnt != 2 || pop_cnt != 2 || s_out_valid) begin
         miscompares++;
         $display("FAIL halt_drain got req=%0d pops=%0d valid=%b want 2/2/0", req_cnt, pop_cnt, s_out_valid);
      end
      forced_step(1'b1, 32'h0000_0040, 1'b0);
      seen_req = 0;
      repeat (6) begin
         step();
         if (s_fire && !seen_req) begin
            seen_req = 1; vectors++;
            if (s_req_addr !== 32'h40) begin
               miscompares++;
               $display("FAIL halt_resume got=%h want=%h", s_req_addr, 32'h40);
            end
         end
      end
   endtask

   task automatic test_wrap();
      Word addrs[2];
      int n;
      set_knobs(1, 100, 100, 0, 0);
      apply_reset();
      repeat (2) step();
      forced_step(1'b1, 32'hFFFF_FFFF, 1'b0);
      n = 0;
      repeat (8) begin
         step();
         if (s_fire && n < 2) begin addrs[n] = s_req_addr; n++; end
      end
      vectors++;
      if (n != 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap got n=%0d a0=%h a1=%h want 2/fffffffc/0", n, addrs[0], addrs[1]);
      end
   endtask

   task automatic test_random();
      for (int ph = 0; ph < 4; ph++) begin
         set_knobs(ph + 1, 40 + 20 * ph, 70 - 15 * ph, 3, 2);
         apply_reset();
         repeat (500) step();
`ifdef FETCH_STATS_EN
         vectors++;
         if (stat_dropped !== exp_dropped || stat_fetched !== exp_fetched) begin
            miscompares++;
            $display("FAIL rand_stats got %0d/%0d want %0d/%0d", stat_dropped, stat_fetched, exp_dropped, exp_fetched);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
